// File: rtl/gcd_request_sequencer.sv
// Initiator side of a GCD core go/done handshake.
// Operand pairs from the host are buffered in a small FIFO and handed to the core one at a time.
// Results, or error flags when a job is aborted, are returned to the host in request order.
module gcd_request_sequencer #(
  parameter int DEPTH   = 4,   // request FIFO entries, power of 2
  parameter int TIMEOUT = 63   // max WAIT cycles before the job is aborted
) (
  input  logic       clk,
  input  logic       reset,
  // host request channel
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  // GCD core side
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic       go_o,
  input  logic       done_i,
  input  logic [3:0] gcd_i,
  // host result channel
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_gcd,
  output logic       res_err,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RELEASE,
    S_OUTPUT
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and pointers
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic [7:0]    head;

  // job datapath registers
  logic [3:0]    x_q, y_q, gcd_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          operand_zero;

  // Ready comes from the registered count only, so a pop in a full cycle never frees a slot early.
  assign req_ready    = (count_q != FULL_CNT);
  assign push         = req_valid && req_ready;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign head         = mem_q[rd_ptr_q];
  assign operand_zero = (x_q == 4'd0) || (y_q == 4'd0);

  // FIFO storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_x, req_y};
    end
  end

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (count_q != '0) state_d = S_LOAD;
      S_LOAD:    state_d = operand_zero ? S_OUTPUT : S_WAIT;
      S_WAIT:    if (done_i || (cnt_q == LAST_WAIT)) state_d = S_RELEASE;
      S_RELEASE: if (!done_i) state_d = S_OUTPUT;
      S_OUTPUT:  if (res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: go only in WAIT, so the core is released for at least RELEASE+OUTPUT+IDLE+LOAD
  always_comb begin
    go_o      = (state_q == S_WAIT);
    res_valid = (state_q == S_OUTPUT);
    busy      = (state_q != S_IDLE);
  end

  // Job datapath: operand capture, trivial-case results, core result and timeout handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      gcd_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            x_q <= head[7:4];
            y_q <= head[3:0];
          end
        end
        S_LOAD: begin
          cnt_q <= '0;
          if (operand_zero) begin
            gcd_q <= x_q | y_q;
            err_q <= (x_q == 4'd0) && (y_q == 4'd0);
          end
        end
        S_WAIT: begin
          if (done_i) begin
            gcd_q <= gcd_i;
            err_q <= 1'b0;
          end else if (cnt_q == LAST_WAIT) begin
            gcd_q <= '0;
            err_q <= 1'b1;
          end
          // the exit condition fires at LAST_WAIT, so the counter never wraps
          if (cnt_q != LAST_WAIT) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign res_gcd = gcd_q;
  assign res_err = err_q;

endmodule

// File: tb/tb_gcd_request_sequencer.sv
// Scoreboard bench for gcd_request_sequencer with a behavioural GCD core.
// The core raises DONE core_k cycles after go rises and drops it one cycle after go falls.
module tb_gcd_request_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_x = '0, req_y = '0;
  logic [3:0] x_o, y_o;
  logic       go_o;
  logic       done_i = 1'b0;
  logic [3:0] gcd_i;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_gcd;
  logic       res_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  gcd_request_sequencer #(.DEPTH(4), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .x_o(x_o), .y_o(y_o), .go_o(go_o), .done_i(done_i), .gcd_i(gcd_i),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural GCD core
  int core_k = 5;
  int core_cnt = 0;

  function automatic logic [3:0] gcd4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x, y, t;
    x = a; y = b;
    for (int i = 0; i < 20; i++) begin
      if (y != 0) begin t = x % y; x = y; y = t; end
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (!go_o) begin
      core_cnt <= 0;
      done_i   <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_k) done_i <= 1'b1;
    end
  end

  assign gcd_i = done_i ? gcd4(x_o, y_o) : 4'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // scoreboard: {err, gcd} per accepted request
  logic [4:0] exp_q[$];
  int res_n = 0;

  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        res_n++;
        $display("result %0d: gcd=%0d err=%0d expected gcd=%0d err=%0d",
                 res_n, res_gcd, res_err, e[3:0], e[4]);
        check("res_gcd", res_gcd, e[3:0]);
        check("res_err", res_err, e[4]);
      end
    end
  end

  // go_o / res_valid activity tracking
  int cyc = 0;
  int go_rises = 0, go_rise_cyc = 0, rv_rise_cyc = 0, go_len = 0;
  int low_run = 0, min_gap = 1000;
  bit seen_go = 0, go_prev = 0, rv_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      go_prev = 0; rv_prev = 0; low_run = 0; seen_go = 0;
    end else begin
      if (go_o && !go_prev) begin
        go_rises++;
        go_rise_cyc = cyc;
        go_len = 0;
        if (seen_go && low_run < min_gap) min_gap = low_run;
        seen_go = 1;
      end
      if (go_o) begin go_len++; low_run = 0; end
      else low_run++;
      if (res_valid && !rv_prev) rv_rise_cyc = cyc;
      go_prev = go_o;
      rv_prev = res_valid;
    end
  end

  task automatic push(input logic [3:0] x, input logic [3:0] y,
                      input logic [3:0] eg, input logic ee);
    int n;
    n = 0;
    req_valid = 1'b1; req_x = x; req_y = y;
    while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      timeout_fail("push_ready");
    end else begin
      @(posedge clk);
      exp_q.push_back({ee, eg});
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0 || busy) timeout_fail(name);
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (!go_o && n < 200) begin @(posedge clk); #1; n++; end
    if (!go_o) timeout_fail(name);
  endtask

  initial begin
    int rises_before;
    bit stable;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {go_o, x_o, y_o, res_valid, res_gcd, res_err, busy}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_req_ready", req_ready, 1);

    // single job with latency measurement: (12,9) -> 3, DONE after 5 cycles
    core_k = 5;
    push(4'd12, 4'd9, 4'd3, 1'b0);
    wait_go("go_rise_single");
    check("x_o_single", x_o, 12);
    check("y_o_single", y_o, 9);
    drain("drain_single");
    check("latency_k_plus_3", rv_rise_cyc - go_rise_cyc, 8);

    // back-to-back jobs return in order: (9,8)->1, (12,9)->3
    push(4'd9, 4'd8, 4'd1, 1'b0);
    push(4'd12, 4'd9, 4'd3, 1'b0);
    drain("drain_b2b");

    // stalled core: one job in flight plus four queued fills the FIFO
    core_k = 30;
    push(4'd8, 4'd12, 4'd4, 1'b0);
    push(4'd15, 4'd10, 4'd5, 1'b0);
    push(4'd7, 4'd7, 4'd7, 1'b0);
    push(4'd14, 4'd21 - 4'd16, 4'd1, 1'b0);   // (14,5) -> 1
    push(4'd6, 4'd9, 4'd3, 1'b0);
    check("req_ready_full", req_ready, 0);
    check("busy_full", busy, 1);
    drain("drain_full");

    // zero operands bypass the core
    core_k = 5;
    rises_before = go_rises;
    push(4'd0, 4'd7, 4'd7, 1'b0);
    push(4'd0, 4'd0, 4'd0, 1'b1);
    drain("drain_zero");
    check("no_go_for_zero", go_rises, rises_before);

    // core never answers: abort after 63 WAIT cycles, next job still runs
    core_k = 100000;
    push(4'd6, 4'd4, 4'd0, 1'b1);
    wait_go("go_rise_timeout");
    begin
      int n;
      n = 0;
      while (go_o && n < 200) begin @(posedge clk); #1; n++; end
      if (go_o) timeout_fail("go_fall_timeout");
    end
    check("timeout_wait_cycles", go_len, 63);
    core_k = 5;
    push(4'd10, 4'd15, 4'd5, 1'b0);
    drain("drain_timeout");

    // result held under backpressure, then reset during WAIT of the next job
    res_ready = 1'b0;
    push(4'd12, 4'd8, 4'd4, 1'b0);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
      if (!res_valid) timeout_fail("res_valid_hold");
    end
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!res_valid || res_gcd != 4'd4 || res_err != 1'b0) stable = 0;
    end
    check("result_stable_hold", stable, 1);
    core_k = 50;
    push(4'd5, 4'd10, 4'd5, 1'b0);
    push(4'd3, 4'd6, 4'd3, 1'b0);
    res_ready = 1'b1;
    wait_go("go_rise_before_reset");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("go_drop_async", go_o, 0);
    exp_q.delete();
    check("reset_outputs_midwait", {go_o, x_o, y_o, res_valid, res_gcd, res_err, busy}, 0);
    check("req_ready_in_reset", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || res_valid || go_o) stable = 0;
    end
    check("fifo_empty_after_reset", stable, 1);

    // sequencer still usable after the reset
    core_k = 5;
    push(4'd7, 4'd14, 4'd7, 1'b0);
    drain("drain_after_reset");

    check("min_go_low_gap_ge2", (min_gap >= 2) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcd_request_sequencer.md
GCD_REQUEST_SEQUENCER -- requirements
Module: gcd_request_sequencer
Purpose: initiator side of the GCD core go/done interface; queues operand pairs, drives the core, returns results.

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries (power of 2).
REQ-002 SHALL have parameter TIMEOUT, default 63: max WAIT cycles before abort.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  host offers operand pair.
REQ-006 SHALL have port req_ready  out  1  FIFO not full.
REQ-007 SHALL have ports req_x, req_y  in  4 each  operands.
REQ-008 SHALL have ports x_o, y_o  out  4 each  operands to core (x_i, y_i).
REQ-009 SHALL have port go_o  out  1  core go_i.
REQ-010 SHALL have port done_i  in  1  core DONE.
REQ-011 SHALL have port gcd_i  in  4  core GCD_OUT.
REQ-012 SHALL have port res_valid  out  1  result available.
REQ-013 SHALL have port res_ready  in  1  host accepts result.
REQ-014 SHALL have ports res_gcd  out  4  and res_err  out  1  result value and error flag.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL push {req_x, req_y} on a clock edge where req_valid && req_ready; req_ready = !full, from registered count only.
REQ-017 SHALL, when full with a pop in the same cycle, not accept a push that cycle.
REQ-018 SHALL implement FSM states IDLE, LOAD, WAIT, RELEASE, OUTPUT.
REQ-019 IDLE: if FIFO non-empty, pop and register the head into x_o/y_o, then go to LOAD; otherwise stay.
REQ-020 LOAD: if x_o==0 or y_o==0, set res_gcd = x_o|y_o and res_err = (both zero), then go to OUTPUT without asserting go_o; otherwise go to WAIT.
REQ-021 WAIT: go_o=1; x_o/y_o SHALL hold stable; clear the cycle counter on entry and increment it each cycle.
REQ-022 WAIT: on done_i==1, capture gcd_i into res_gcd with res_err=0, then go to RELEASE.
REQ-023 WAIT: when the counter reaches TIMEOUT without done_i, set res_gcd=0 and res_err=1, then go to RELEASE.
REQ-024 RELEASE: go_o=0; stay until done_i==0 (core returned to its idle state), then go to OUTPUT.
REQ-025 OUTPUT: res_valid=1 with res_gcd/res_err stable; on res_ready, go to IDLE next cycle.
REQ-026 go_o SHALL be 0 in every state except WAIT; there SHALL be at least 2 go_o-low cycles between jobs.
REQ-027 Latency, no backpressure, core DONE after k cycles: res_valid rises k+3 cycles after go_o rises.
REQ-028 Results SHALL be returned in request order; no reordering or drop.
REQ-029 The cycle counter SHALL be wide enough for TIMEOUT and SHALL NOT wrap inside WAIT.

Reset
REQ-030 On reset: state=IDLE, FIFO empty, count=0.
REQ-031 On reset, these outputs SHALL be 0: go_o, x_o, y_o, res_valid, res_gcd, res_err, busy, counter.
REQ-032 On reset, req_ready SHALL be 1 after release.
REQ-033 Reset asserted mid-WAIT SHALL drop go_o immediately (asynchronous) and discard queued and in-flight jobs.

Verification
REQ-034 Push (12,9), core model DONE after 5 cycles -> x_o=12, y_o=9, go_o high until DONE; res_gcd=3, res_err=0.
REQ-035 Push (9,8), then (12,9) back-to-back -> results 1 then 3 in order; go_o low at least 2 cycles between jobs.
REQ-036 Push 5 pairs with the core stalled -> req_ready=0 after 4 accepted beyond the in-flight job; no loss once drained.
REQ-037 Push (0,7) and (0,0) -> no go_o pulse; results 7/err=0 and 0/err=1.
REQ-038 Core never asserts DONE -> go_o drops after TIMEOUT=63 WAIT cycles; res_gcd=0, res_err=1; next job proceeds.
REQ-039 Hold res_ready=0 for 10 cycles, then assert reset during WAIT of the next job -> result held stable; then all outputs 0 and FIFO empty.
